mem_arbiter: RTL

Single-port memory arbiter and sequencer for the RISC-V core. It shares one memory port between instruction fetch (IF) and the data accesses (LW/SW) that the control unit flags as memory-enabled in the MEM stage. It runs one transaction at a time through a small FSM, applies fixed MEM-over-IF priority, and generates the pipeline STALL. A watchdog aborts transactions that the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port memory arbiter/sequencer. Shares one RAM port
//            between instruction fetch and MEM-stage data accesses with fixed
//            MEM-over-IF priority. Runs one transaction at a time, generates
//            the pipeline STALL and aborts unacknowledged accesses through a
//            watchdog that raises a sticky ERR flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        IF_req,
    input  logic [31:0] IF_addr,
    output logic [31:0] IF_rdata,
    output logic        IF_valid,
    input  logic        MEM_req,
    input  logic        MEM_wr,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_wdata,
    output logic [31:0] MEM_rdata,
    output logic        MEM_done,
    output logic        STALL,
    output logic        ERR,
    output logic        RAM_en,
    output logic        RAM_wr,
    output logic [31:0] RAM_addr,
    output logic [31:0] RAM_wdata,
    input  logic [31:0] RAM_rdata,
    input  logic        RAM_ready
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    // Abort happens on the cycle the counter would reach TIMEOUT, so RAM_en
    // stays high for exactly TIMEOUT cycles.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic                 r_ram_en_q,    w_ram_en_d;
    logic                 r_ram_wr_q,    w_ram_wr_d;
    logic [31:0]          r_ram_addr_q,  w_ram_addr_d;
    logic [31:0]          r_ram_wdata_q, w_ram_wdata_d;
    logic [31:0]          r_if_rdata_q,  w_if_rdata_d;
    logic [31:0]          r_mem_rdata_q, w_mem_rdata_d;
    logic                 r_if_valid_q,  w_if_valid_d;
    logic                 r_mem_done_q,  w_mem_done_d;
    logic                 r_err_q,       w_err_d;
    logic [c_CNT_W-1:0]   r_cnt_q,       w_cnt_d;

    // A port whose done pulse is high this cycle is not eligible, which
    // prevents a second grant of the same still-held request.
    logic w_mem_elig;
    logic w_if_elig;
    assign w_mem_elig = MEM_req & ~r_mem_done_q;
    assign w_if_elig  = IF_req  & ~r_if_valid_q;

    // Next-state, grant, completion and watchdog logic
    always_comb begin
        w_state_d     = r_state_q;
        w_ram_en_d    = r_ram_en_q;
        w_ram_wr_d    = r_ram_wr_q;
        w_ram_addr_d  = r_ram_addr_q;
        w_ram_wdata_d = r_ram_wdata_q;
        w_if_rdata_d  = r_if_rdata_q;
        w_mem_rdata_d = r_mem_rdata_q;
        w_if_valid_d  = 1'b0;
        w_mem_done_d  = 1'b0;
        w_err_d       = r_err_q;
        w_cnt_d       = r_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_mem_elig) begin
                    w_state_d     = S_BUSY_MEM;
                    w_ram_en_d    = 1'b1;
                    w_ram_wr_d    = MEM_wr;
                    w_ram_addr_d  = MEM_addr;
                    w_ram_wdata_d = MEM_wdata;
                    w_cnt_d       = '0;
                end else if (w_if_elig) begin
                    w_state_d     = S_BUSY_IF;
                    w_ram_en_d    = 1'b1;
                    w_ram_wr_d    = 1'b0;
                    w_ram_addr_d  = IF_addr;
                    w_ram_wdata_d = 32'd0;
                    w_cnt_d       = '0;
                end
            end

            S_BUSY_IF, S_BUSY_MEM: begin
                if (RAM_ready || (r_cnt_q == c_CNT_LAST)) begin
                    // Completion or watchdog abort; an abort returns zero data.
                    w_state_d  = S_IDLE;
                    w_ram_en_d = 1'b0;
                    w_cnt_d    = '0;
                    if (!RAM_ready) begin
                        w_err_d = 1'b1;
                    end
                    if (r_state_q == S_BUSY_IF) begin
                        w_if_rdata_d = RAM_ready ? RAM_rdata : 32'd0;
                        w_if_valid_d = 1'b1;
                    end else begin
                        if (!r_ram_wr_q) begin
                            w_mem_rdata_d = RAM_ready ? RAM_rdata : 32'd0;
                        end
                        w_mem_done_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            default: begin
                w_state_d  = S_IDLE;
                w_ram_en_d = 1'b0;
                w_cnt_d    = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state_q     <= S_IDLE;
            r_ram_en_q    <= 1'b0;
            r_ram_wr_q    <= 1'b0;
            r_ram_addr_q  <= 32'd0;
            r_ram_wdata_q <= 32'd0;
            r_if_rdata_q  <= 32'd0;
            r_mem_rdata_q <= 32'd0;
            r_if_valid_q  <= 1'b0;
            r_mem_done_q  <= 1'b0;
            r_err_q       <= 1'b0;
            r_cnt_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ram_en_q    <= w_ram_en_d;
            r_ram_wr_q    <= w_ram_wr_d;
            r_ram_addr_q  <= w_ram_addr_d;
            r_ram_wdata_q <= w_ram_wdata_d;
            r_if_rdata_q  <= w_if_rdata_d;
            r_mem_rdata_q <= w_mem_rdata_d;
            r_if_valid_q  <= w_if_valid_d;
            r_mem_done_q  <= w_mem_done_d;
            r_err_q       <= w_err_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    assign STALL     = (IF_req & ~r_if_valid_q) | (MEM_req & ~r_mem_done_q);
    assign IF_rdata  = r_if_rdata_q;
    assign IF_valid  = r_if_valid_q;
    assign MEM_rdata = r_mem_rdata_q;
    assign MEM_done  = r_mem_done_q;
    assign ERR       = r_err_q;
    assign RAM_en    = r_ram_en_q;
    assign RAM_wr    = r_ram_wr_q;
    assign RAM_addr  = r_ram_addr_q;
    assign RAM_wdata = r_ram_wdata_q;

endmodule
`default_nettype wire
